// File: rtl/gtech_evt_capture4.sv
// Four-channel event capture feeding a 4-input OR summary line.
// Ports: CLK, RST (async high); EVT_IN/CLR/MASK [3:0] in;
//   FLAG/OVF/REQ [3:0] out; CNT [4*CW-1:0] packed per-channel counters.
module gtech_evt_capture4 #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE        = 1'b1,
    parameter int CW          = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [3:0]      EVT_IN,
    input  logic [3:0]      CLR,
    input  logic [3:0]      MASK,
    output logic [3:0]      FLAG,
    output logic [3:0]      OVF,
    output logic [3:0]      REQ,
    output logic [4*CW-1:0] CNT
);

    logic [3:0]    evt_s;
    logic [3:0]    hit;
    logic [3:0]    flag_nxt;
    logic [3:0]    ovf_nxt;
    logic [CW-1:0] cnt_q   [4];
    logic [CW-1:0] cnt_nxt [4];

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign evt_s = EVT_IN;
        end else begin : g_sync
            logic [3:0] stg [SYNC_STAGES];
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < SYNC_STAGES; i++)
                        stg[i] <= '0;
                end else begin
                    stg[0] <= EVT_IN;
                    for (int i = 1; i < SYNC_STAGES; i++)
                        stg[i] <= stg[i-1];
                end
            end
            assign evt_s = stg[SYNC_STAGES-1];
        end
    endgenerate

    generate
        if (EDGE) begin : g_edge
            // History resets to 0, so an input already high at
            // reset release produces exactly one hit.
            logic [3:0] evt_d;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    evt_d <= '0;
                else
                    evt_d <= evt_s;
            end
            assign hit = evt_s & ~evt_d;
        end else begin : g_level
            assign hit = evt_s;
        end
    endgenerate

    always_comb begin
        flag_nxt = '0;
        ovf_nxt  = '0;
        for (int n = 0; n < 4; n++) begin
            cnt_nxt[n] = cnt_q[n];
            // Set has priority over clear.
            flag_nxt[n] = hit[n] | (FLAG[n] & ~CLR[n]);
            if (CLR[n] && hit[n])
                cnt_nxt[n] = CNT_ONE;
            else if (CLR[n])
                cnt_nxt[n] = '0;
            else if (hit[n] && cnt_q[n] != CNT_MAX)
                cnt_nxt[n] = cnt_q[n] + CNT_ONE;
            // A clear restarts the counter, so it also drops overflow
            // even when a saturated hit lands on the same cycle.
            if (CLR[n])
                ovf_nxt[n] = 1'b0;
            else if (hit[n] && cnt_q[n] == CNT_MAX)
                ovf_nxt[n] = 1'b1;
            else
                ovf_nxt[n] = OVF[n];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            FLAG <= '0;
            OVF  <= '0;
            REQ  <= '0;
            for (int n = 0; n < 4; n++)
                cnt_q[n] <= '0;
        end else begin
            FLAG <= flag_nxt;
            OVF  <= ovf_nxt;
            REQ  <= flag_nxt & ~MASK;
            for (int n = 0; n < 4; n++)
                cnt_q[n] <= cnt_nxt[n];
        end
    end

    always_comb begin
        CNT = '0;
        for (int n = 0; n < 4; n++)
            CNT[n*CW +: CW] = cnt_q[n];
    end

endmodule

// File: tb/tb_gtech_evt_capture4.sv
// Directed bench for gtech_evt_capture4: edge mode (u_edge)
// and level mode (u_lvl), both with two sync stages and CW=4.
module tb_gtech_evt_capture4;

    logic        CLK;
    logic        RST;

    logic [3:0]  e_evt, e_clr, e_mask;
    logic [3:0]  e_flag, e_ovf, e_req;
    logic [15:0] e_cnt;

    logic [3:0]  l_evt, l_clr, l_mask;
    logic [3:0]  l_flag, l_ovf, l_req;
    logic [15:0] l_cnt;

    int tests;
    int fails;

    gtech_evt_capture4 #(.SYNC_STAGES(2), .EDGE(1'b1), .CW(4)) u_edge (
        .CLK(CLK), .RST(RST), .EVT_IN(e_evt), .CLR(e_clr),
        .MASK(e_mask), .FLAG(e_flag), .OVF(e_ovf), .REQ(e_req),
        .CNT(e_cnt)
    );

    gtech_evt_capture4 #(.SYNC_STAGES(2), .EDGE(1'b0), .CW(4)) u_lvl (
        .CLK(CLK), .RST(RST), .EVT_IN(l_evt), .CLR(l_clr),
        .MASK(l_mask), .FLAG(l_flag), .OVF(l_ovf), .REQ(l_req),
        .CNT(l_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RST = 1'b1;
        e_evt = '0; e_clr = '0; e_mask = '0;
        l_evt = '0; l_clr = '0; l_mask = '0;
        step(3);
        chk("rst_flag", {28'd0, e_flag}, 32'h0);
        chk("rst_cnt", {16'd0, e_cnt}, 32'h0);
        chk("rst_req_ovf", {24'd0, e_req, e_ovf}, 32'h0);
        chk("rst_lvl", {12'd0, l_flag, l_cnt}, 32'h0);
        RST = 1'b0;
        step(3);
        chk("idle_flag", {28'd0, e_flag}, 32'h0);

        // Latency: flag appears after the second edge past the first.
        e_evt = 4'b0100;
        step(1);
        chk("lat_e1", {28'd0, e_flag}, 32'h0);
        step(1);
        chk("lat_e2", {28'd0, e_flag}, 32'h0);
        step(1);
        chk("lat_flag", {28'd0, e_flag}, 32'h4);
        chk("lat_req", {28'd0, e_req}, 32'h4);
        chk("lat_cnt2", {28'd0, e_cnt[11:8]}, 32'h1);
        step(3);
        chk("hold_cnt2", {28'd0, e_cnt[11:8]}, 32'h1);
        e_evt = 4'b0000;
        step(3);

        // Build FLAG=1011 and CNT0=7, then clear channel 2.
        for (int i = 0; i < 7; i++) begin
            e_evt = (i == 0) ? 4'b1011 : 4'b0001;
            step(1);
            e_evt = 4'b0000;
            step(1);
        end
        step(3);
        e_clr = 4'b0100;
        step(1);
        e_clr = 4'b0000;
        chk("pre_rst_flag", {28'd0, e_flag}, 32'hB);
        chk("pre_rst_cnt", {16'd0, e_cnt}, 32'h1017);

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2 RST = 1'b1;
        #1;
        chk("async_flag", {28'd0, e_flag}, 32'h0);
        chk("async_cnt", {16'd0, e_cnt}, 32'h0);
        chk("async_req", {28'd0, e_req}, 32'h0);
        step(2);
        RST = 1'b0;
        step(3);
        chk("post_rst", {12'd0, e_flag, e_cnt}, 32'h0);

        // Set/clear collision on channel 1 with CNT1=3.
        for (int i = 0; i < 3; i++) begin
            e_evt = 4'b0010;
            step(1);
            e_evt = 4'b0000;
            step(1);
        end
        step(3);
        chk("pre_col_cnt1", {28'd0, e_cnt[7:4]}, 32'h3);
        e_evt = 4'b0010;
        step(2);
        e_clr = 4'b0010;
        step(1);
        chk("col_flag1", {31'd0, e_flag[1]}, 32'h1);
        chk("col_cnt1", {28'd0, e_cnt[7:4]}, 32'h1);
        chk("col_ovf1", {31'd0, e_ovf[1]}, 32'h0);
        step(1);
        chk("clr_flag1", {31'd0, e_flag[1]}, 32'h0);
        chk("clr_cnt1", {28'd0, e_cnt[7:4]}, 32'h0);
        e_clr = 4'b0000;
        e_evt = 4'b0000;
        step(3);

        // Simultaneous hits on all channels.
        e_evt = 4'b1111;
        step(3);
        chk("sim_flag", {28'd0, e_flag}, 32'hF);
        chk("sim_cnt", {16'd0, e_cnt}, 32'h1111);
        chk("sim_req", {28'd0, e_req}, 32'hF);
        e_evt = 4'b0000;
        step(3);

        // Masking.
        e_mask = 4'b0101;
        step(1);
        chk("mask_req", {28'd0, e_req}, 32'hA);
        chk("mask_flag", {28'd0, e_flag}, 32'hF);
        e_mask = 4'b0000;
        step(1);
        chk("unmask_req", {28'd0, e_req}, 32'hF);
        chk("unmask_flag", {28'd0, e_flag}, 32'hF);

        // Level mode: six high cycles give six counts.
        l_evt = 4'b0001;
        step(6);
        l_evt = 4'b0000;
        step(3);
        chk("lvl_cnt6", {28'd0, l_cnt[3:0]}, 32'h6);
        chk("lvl_flag", {28'd0, l_flag}, 32'h1);
        l_clr = 4'b0001;
        step(1);
        l_clr = 4'b0000;
        chk("lvl_clr", {28'd0, l_cnt[3:0]}, 32'h0);

        // Saturation: 15th hit reaches max, 16th sets overflow.
        l_evt = 4'b0001;
        step(17);
        chk("sat15_cnt", {28'd0, l_cnt[3:0]}, 32'hF);
        chk("sat15_ovf", {31'd0, l_ovf[0]}, 32'h0);
        step(1);
        chk("sat16_ovf", {31'd0, l_ovf[0]}, 32'h1);
        chk("sat16_cnt", {28'd0, l_cnt[3:0]}, 32'hF);
        step(2);
        l_evt = 4'b0000;
        step(3);
        chk("sat_end_cnt", {28'd0, l_cnt[3:0]}, 32'hF);
        chk("sat_end_ovf", {28'd0, l_ovf}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
